// File: rtl/btb_ctrl_if.sv
// Fetch lookup, prediction return and resolved-branch update channels of btb_ctrl.
// The master side drives requests; the slave side (btb_ctrl) accepts and predicts.
interface btb_ctrl_if;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_ready;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        u_valid;
  logic        u_ready;
  logic [31:0] u_pc;
  logic        u_taken;
  logic [31:0] u_target;

  modport master (
    output f_valid, f_pc, u_valid, u_pc, u_taken, u_target,
    input  f_ready, pred_valid, pred_hit, pred_taken, pred_target, u_ready
  );

  modport slave (
    input  f_valid, f_pc, u_valid, u_pc, u_taken, u_target,
    output f_ready, pred_valid, pred_hit, pred_taken, pred_target, u_ready
  );
endinterface

// File: rtl/btb_ctrl.sv
// Lookup/update controller for a 2-way branch target buffer array.
// Fetch lookups share the array read port with read-modify-write updates drained from a 2-entry FIFO.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no update pending
//   S_READ  | head update waiting for the read port (fetch may win)
//   S_WRITE | latched read result applied to the array, FIFO popped
module btb_ctrl #(
  parameter  int SETS = 8,
  parameter  int TAGW = 27,
  localparam int IW   = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst,
  btb_ctrl_if.slave       bus,
  output logic [IW-1:0]   fb_rd_set,
  output logic            fb_rd_way0,
  output logic            fb_rd_way1,
  input  logic            fb_rd_valid0,
  input  logic            fb_rd_valid1,
  input  logic [TAGW-1:0] fb_rd_tag0,
  input  logic [TAGW-1:0] fb_rd_tag1,
  input  logic [31:0]     fb_rd_target0,
  input  logic [31:0]     fb_rd_target1,
  input  logic [1:0]      fb_rd_state0,
  input  logic [1:0]      fb_rd_state1,
  input  logic            fb_rd_lru,
  output logic            fb_wr_en,
  output logic [IW-1:0]   fb_wr_set,
  output logic            fb_wr_way,
  output logic            fb_wr_valid,
  output logic [TAGW-1:0] fb_wr_tag,
  output logic [31:0]     fb_wr_target,
  output logic [1:0]      fb_wr_state,
  output logic            fb_wr_lru_en,
  output logic            fb_wr_lru_val
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t state, state_nxt;

  // update FIFO; word offset bits of the pc are never needed
  logic [31:2] q_pc     [2];
  logic        q_taken  [2];
  logic [31:0] q_target [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_nxt;
  logic        push, pop;

  logic [31:2]     head_pc;
  logic            head_taken;
  logic [31:0]     head_target;
  logic [TAGW-1:0] head_tag;

  logic [1:0]  wait_cnt;
  logic        upd_grant;
  logic        f_ready_int;
  logic        f_acc;

  logic [31:2]     cmp_pc;
  logic [TAGW-1:0] cmp_tag;
  logic            hit0, hit1, rd_hit;
  logic [1:0]      sel_state;
  logic [31:0]     sel_target;

  logic        l_hit, l_way, l_lru;
  logic [1:0]  l_state;
  logic [31:0] l_target;

  logic        pred_valid_r, pred_hit_r, pred_taken_r;
  logic [31:0] pred_target_r;

  assign head_pc     = q_pc[rd_ptr];
  assign head_taken  = q_taken[rd_ptr];
  assign head_target = q_target[rd_ptr];
  assign head_tag    = head_pc[31 -: TAGW];

  assign push      = bus.u_valid && bus.u_ready;
  assign pop       = (state == S_WRITE);
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};

  assign bus.u_ready = (count != 2'd2);

  // fetch owns the port unless an update has already yielded three times
  assign upd_grant   = (state == S_READ) && (!bus.f_valid || wait_cnt == 2'd3);
  assign f_ready_int = !((state == S_READ) && (wait_cnt == 2'd3));
  assign f_acc       = bus.f_valid && f_ready_int;
  assign bus.f_ready = f_ready_int;

  assign cmp_pc     = upd_grant ? head_pc : bus.f_pc[31:2];
  assign cmp_tag    = cmp_pc[31 -: TAGW];
  assign fb_rd_set  = cmp_pc[IW+1:2];
  assign fb_rd_way0 = 1'b0;
  assign fb_rd_way1 = 1'b1;

  // way 0 takes priority when both ways match
  assign hit0       = fb_rd_valid0 && (fb_rd_tag0 == cmp_tag);
  assign hit1       = fb_rd_valid1 && (fb_rd_tag1 == cmp_tag);
  assign rd_hit     = hit0 || hit1;
  assign sel_state  = hit0 ? fb_rd_state0  : fb_rd_state1;
  assign sel_target = hit0 ? fb_rd_target0 : fb_rd_target1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_pc[i]     <= '0;
        q_taken[i]  <= 1'b0;
        q_target[i] <= '0;
      end
    end else begin
      if (push) begin
        q_pc[wr_ptr]     <= bus.u_pc[31:2];
        q_taken[wr_ptr]  <= bus.u_taken;
        q_target[wr_ptr] <= bus.u_target;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count != 2'd0) state_nxt = S_READ;
      S_READ:  if (upd_grant) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (count_nxt != 2'd0) ? S_READ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   wait_cnt <= 2'd0;
    else if (upd_grant)                        wait_cnt <= 2'd0;
    else if (state == S_READ && bus.f_valid)   wait_cnt <= wait_cnt + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_hit    <= 1'b0;
      l_way    <= 1'b0;
      l_state  <= 2'b00;
      l_target <= '0;
      l_lru    <= 1'b0;
    end else if (upd_grant) begin
      l_hit    <= rd_hit;
      l_way    <= !hit0;
      l_state  <= sel_state;
      l_target <= sel_target;
      l_lru    <= fb_rd_lru;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_r  <= 1'b0;
      pred_hit_r    <= 1'b0;
      pred_taken_r  <= 1'b0;
      pred_target_r <= '0;
    end else begin
      pred_valid_r  <= f_acc;
      pred_hit_r    <= f_acc && rd_hit;
      pred_taken_r  <= f_acc && rd_hit && sel_state[1];
      pred_target_r <= (f_acc && rd_hit) ? sel_target : '0;
    end
  end

  assign bus.pred_valid  = pred_valid_r;
  assign bus.pred_hit    = pred_hit_r;
  assign bus.pred_taken  = pred_taken_r;
  assign bus.pred_target = pred_target_r;

  always_comb begin
    fb_wr_en      = 1'b0;
    fb_wr_set     = '0;
    fb_wr_way     = 1'b0;
    fb_wr_valid   = 1'b0;
    fb_wr_tag     = '0;
    fb_wr_target  = '0;
    fb_wr_state   = 2'b00;
    fb_wr_lru_en  = 1'b0;
    fb_wr_lru_val = 1'b0;
    if (state == S_WRITE) begin
      if (l_hit) begin
        fb_wr_en      = 1'b1;
        fb_wr_set     = head_pc[IW+1:2];
        fb_wr_way     = l_way;
        fb_wr_valid   = 1'b1;
        fb_wr_tag     = head_tag;
        if (head_taken)
          fb_wr_state = (l_state == 2'b11) ? 2'b11 : l_state + 2'b01;
        else
          fb_wr_state = (l_state == 2'b00) ? 2'b00 : l_state - 2'b01;
        fb_wr_target  = head_taken ? head_target : l_target;
        fb_wr_lru_en  = 1'b1;
        fb_wr_lru_val = ~l_way;
      end else if (head_taken) begin
        // allocate in the LRU victim, starting weakly taken
        fb_wr_en      = 1'b1;
        fb_wr_set     = head_pc[IW+1:2];
        fb_wr_way     = l_lru;
        fb_wr_valid   = 1'b1;
        fb_wr_tag     = head_tag;
        fb_wr_state   = 2'b10;
        fb_wr_target  = head_target;
        fb_wr_lru_en  = 1'b1;
        fb_wr_lru_val = ~l_lru;
      end
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl: a behavioural 2-way array plus scoreboards for
// predictions and array writes, driven from a vector table and a few timing sequences.
module tb_btb_ctrl;
  localparam int TAGW = 27;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arr_rst = 1'b1;
  always #5 clk = ~clk;

  btb_ctrl_if bus();

  logic [2:0]      fb_rd_set;
  logic            fb_rd_way0, fb_rd_way1;
  logic            fb_rd_valid0, fb_rd_valid1;
  logic [TAGW-1:0] fb_rd_tag0, fb_rd_tag1;
  logic [31:0]     fb_rd_target0, fb_rd_target1;
  logic [1:0]      fb_rd_state0, fb_rd_state1;
  logic            fb_rd_lru;
  logic            fb_wr_en;
  logic [2:0]      fb_wr_set;
  logic            fb_wr_way, fb_wr_valid;
  logic [TAGW-1:0] fb_wr_tag;
  logic [31:0]     fb_wr_target;
  logic [1:0]      fb_wr_state;
  logic            fb_wr_lru_en, fb_wr_lru_val;

  btb_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .fb_rd_set(fb_rd_set), .fb_rd_way0(fb_rd_way0), .fb_rd_way1(fb_rd_way1),
    .fb_rd_valid0(fb_rd_valid0), .fb_rd_valid1(fb_rd_valid1),
    .fb_rd_tag0(fb_rd_tag0), .fb_rd_tag1(fb_rd_tag1),
    .fb_rd_target0(fb_rd_target0), .fb_rd_target1(fb_rd_target1),
    .fb_rd_state0(fb_rd_state0), .fb_rd_state1(fb_rd_state1),
    .fb_rd_lru(fb_rd_lru),
    .fb_wr_en(fb_wr_en), .fb_wr_set(fb_wr_set), .fb_wr_way(fb_wr_way),
    .fb_wr_valid(fb_wr_valid), .fb_wr_tag(fb_wr_tag), .fb_wr_target(fb_wr_target),
    .fb_wr_state(fb_wr_state), .fb_wr_lru_en(fb_wr_lru_en), .fb_wr_lru_val(fb_wr_lru_val)
  );

  // behavioural storage array with its own reset
  logic            a_valid  [8][2];
  logic [TAGW-1:0] a_tag    [8][2];
  logic [31:0]     a_target [8][2];
  logic [1:0]      a_state  [8][2];
  logic            a_lru    [8];
  int              wr_cnt;

  always @(posedge clk or posedge arr_rst) begin
    if (arr_rst) begin
      for (int s = 0; s < 8; s++) begin
        for (int w = 0; w < 2; w++) begin
          a_valid[s][w]  <= 1'b0;
          a_tag[s][w]    <= '0;
          a_target[s][w] <= '0;
          a_state[s][w]  <= 2'b00;
        end
        a_lru[s] <= 1'b0;
      end
      wr_cnt <= 0;
    end else begin
      if (fb_wr_en) begin
        a_valid[fb_wr_set][fb_wr_way]  <= fb_wr_valid;
        a_tag[fb_wr_set][fb_wr_way]    <= fb_wr_tag;
        a_target[fb_wr_set][fb_wr_way] <= fb_wr_target;
        a_state[fb_wr_set][fb_wr_way]  <= fb_wr_state;
        wr_cnt <= wr_cnt + 1;
      end
      if (fb_wr_lru_en) a_lru[fb_wr_set] <= fb_wr_lru_val;
    end
  end

  assign fb_rd_valid0  = a_valid[fb_rd_set][0];
  assign fb_rd_valid1  = a_valid[fb_rd_set][1];
  assign fb_rd_tag0    = a_tag[fb_rd_set][0];
  assign fb_rd_tag1    = a_tag[fb_rd_set][1];
  assign fb_rd_target0 = a_target[fb_rd_set][0];
  assign fb_rd_target1 = a_target[fb_rd_set][1];
  assign fb_rd_state0  = a_state[fb_rd_set][0];
  assign fb_rd_state1  = a_state[fb_rd_set][1];
  assign fb_rd_lru     = a_lru[fb_rd_set];

  int vec  = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  typedef struct packed {
    logic [2:0]      set;
    logic            way;
    logic [TAGW-1:0] tag;
    logic [31:0]     target;
    logic [1:0]      state;
    logic            lru_val;
  } wr_t;

  pred_t pq[$];
  wr_t   wq[$];
  pred_t exp_pred;

  // prediction scoreboard: expectation queued on acceptance, checked one cycle later
  always @(negedge clk) begin
    pred_t e;
    if (!rst) begin
      if (bus.pred_valid) begin
        if (pq.size() == 0) chk("pred_unexpected", bus.pred_valid, 1'b0);
        else begin
          e = pq.pop_front();
          chk("pred", {bus.pred_hit, bus.pred_taken, bus.pred_target}, e);
        end
      end else if (pq.size() != 0) begin
        chk("pred_valid", bus.pred_valid, 1'b1);
        pq.delete();
      end
      if (bus.f_valid && bus.f_ready) pq.push_back(exp_pred);
    end
  end

  // write scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (!rst && (fb_wr_en || fb_wr_lru_en)) begin
      if (wq.size() == 0) chk("wr_unexpected", {fb_wr_en, fb_wr_lru_en}, 2'b00);
      else begin
        e = wq.pop_front();
        chk("write", {fb_wr_en, fb_wr_set, fb_wr_way, fb_wr_valid, fb_wr_tag, fb_wr_target,
                      fb_wr_state, fb_wr_lru_en, fb_wr_lru_val},
                     {1'b1, e.set, e.way, 1'b1, e.tag, e.target, e.state, 1'b1, e.lru_val});
      end
    end
  end

  typedef struct {
    bit          upd;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    pred_t       ep;
    bit          wr;
    wr_t         ew;
  } vec_t;

  function automatic vec_t mk_l(logic [31:0] pc, logic hit, logic tk, logic [31:0] tg);
    vec_t v;
    v.upd = 1'b0; v.pc = pc; v.taken = 1'b0; v.target = '0;
    v.ep = '{hit, tk, tg}; v.wr = 1'b0; v.ew = '0;
    return v;
  endfunction

  function automatic vec_t mk_u(logic [31:0] pc, logic tk, logic [31:0] tg, bit wr,
                                logic way, logic [1:0] st, logic [31:0] wtg, logic lru);
    vec_t v;
    v.upd = 1'b1; v.pc = pc; v.taken = tk; v.target = tg;
    v.ep = '0; v.wr = wr;
    v.ew = '{pc[4:2], way, pc[31:5], wtg, st, lru};
    return v;
  endfunction

  task automatic do_look(input logic [31:0] pc, input pred_t ep);
    exp_pred = ep;
    bus.f_valid = 1'b1;
    bus.f_pc = pc;
    @(posedge clk); #1;
    bus.f_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    for (int k = 0; k < 20 && !bus.u_ready; k++) begin @(posedge clk); #1; end
    chk("u_ready_wait", bus.u_ready, 1'b1);
    bus.u_valid = 1'b1; bus.u_pc = pc; bus.u_taken = tk; bus.u_target = tg;
    @(posedge clk); #1;
    bus.u_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
  endtask

  vec_t tbl[$];
  int   cnt_before;
  logic [7:0] fr_bits, we_bits;
  logic found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.f_valid = 1'b0; bus.f_pc = '0;
    bus.u_valid = 1'b0; bus.u_pc = '0; bus.u_taken = 1'b0; bus.u_target = '0;
    exp_pred = '0;

    tbl.push_back(mk_l(32'h1000, 0, 0, 32'h0));
    tbl.push_back(mk_u(32'h1000, 1, 32'h2000, 1, 0, 2'b10, 32'h2000, 1));
    tbl.push_back(mk_l(32'h1000, 1, 1, 32'h2000));
    tbl.push_back(mk_u(32'h1000, 0, 32'h0,    1, 0, 2'b01, 32'h2000, 1));
    tbl.push_back(mk_u(32'h1000, 0, 32'h0,    1, 0, 2'b00, 32'h2000, 1));
    tbl.push_back(mk_l(32'h1000, 1, 0, 32'h2000));
    tbl.push_back(mk_u(32'h1000, 1, 32'h2000, 1, 0, 2'b01, 32'h2000, 1));
    tbl.push_back(mk_u(32'h2000, 1, 32'h2400, 1, 1, 2'b10, 32'h2400, 0));
    tbl.push_back(mk_u(32'h3000, 1, 32'h3400, 1, 0, 2'b10, 32'h3400, 1));
    tbl.push_back(mk_l(32'h1000, 0, 0, 32'h0));
    tbl.push_back(mk_l(32'h2000, 1, 1, 32'h2400));
    tbl.push_back(mk_u(32'h4004, 0, 32'h4444, 0, 0, 2'b00, 32'h0, 0));
    tbl.push_back(mk_l(32'h3000, 1, 1, 32'h3400));

    repeat (3) @(posedge clk);
    #1; arr_rst = 1'b0;
    @(negedge clk);
    chk("rst_pred", {bus.pred_valid, bus.pred_hit, bus.pred_taken, bus.pred_target}, '0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_pred_after", {bus.pred_valid, bus.pred_hit, bus.pred_taken, bus.pred_target}, '0);
    chk("rst_ready", {bus.u_ready, bus.f_ready}, 2'b11);
    chk("rst_wr", {fb_wr_en, fb_wr_set, fb_wr_way, fb_wr_valid, fb_wr_tag, fb_wr_target,
                   fb_wr_state, fb_wr_lru_en, fb_wr_lru_val}, '0);
    chk("rd_way_const", {fb_rd_way0, fb_rd_way1}, 2'b01);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].upd) begin
        cnt_before = wr_cnt;
        if (tbl[i].wr) wq.push_back(tbl[i].ew);
        do_upd(tbl[i].pc, tbl[i].taken, tbl[i].target);
        chk("write_count", wr_cnt - cnt_before, tbl[i].wr ? 1 : 0);
      end else begin
        do_look(tbl[i].pc, tbl[i].ep);
      end
    end

    // fetch streaming to an empty set while one update waits for the port
    exp_pred = '{1'b0, 1'b0, 32'h0};
    wq.push_back('{3'd0, 1'b1, 27'h100, 32'h2800, 2'b11, 1'b0});
    bus.f_valid = 1'b1; bus.f_pc = 32'h1004;
    bus.u_valid = 1'b1; bus.u_pc = 32'h2000; bus.u_taken = 1'b1; bus.u_target = 32'h2800;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      fr_bits[c] = bus.f_ready;
      we_bits[c] = fb_wr_en;
      @(posedge clk); #1;
      if (c == 0) bus.u_valid = 1'b0;
    end
    bus.f_valid = 1'b0;
    chk("stall_f_ready", fr_bits, 8'b1101_1111);
    chk("stall_wr_en", we_bits, 8'b0100_0000);
    repeat (3) begin @(posedge clk); #1; end

    // lookup to the same set in the write cycle sees pre-write data
    wq.push_back('{3'd0, 1'b1, 27'h100, 32'h2C00, 2'b11, 1'b0});
    bus.u_valid = 1'b1; bus.u_pc = 32'h2000; bus.u_taken = 1'b1; bus.u_target = 32'h2C00;
    @(posedge clk); #1;
    bus.u_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    exp_pred = '{1'b1, 1'b1, 32'h2800};
    bus.f_valid = 1'b1; bus.f_pc = 32'h2000;
    @(negedge clk);
    chk("write_cycle", fb_wr_en, 1'b1);
    @(posedge clk); #1;
    bus.f_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    do_look(32'h2000, '{1'b1, 1'b1, 32'h2C00});

    // fill the FIFO, then reset during the first write
    wq.push_back('{3'd2, 1'b0, 27'h280, 32'h5100, 2'b10, 1'b1});
    bus.u_valid = 1'b1; bus.u_pc = 32'h5008; bus.u_taken = 1'b1; bus.u_target = 32'h5100;
    @(posedge clk); #1;
    chk("u_ready_one", bus.u_ready, 1'b1);
    bus.u_pc = 32'h500C; bus.u_target = 32'h5200;
    @(posedge clk); #1;
    chk("u_ready_full", bus.u_ready, 1'b0);
    bus.u_pc = 32'h5010; bus.u_target = 32'h5300;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      found = fb_wr_en;
    end
    chk("rst_test_write_seen", found, 1'b1);
    #1;
    rst = 1'b1;
    bus.u_valid = 1'b0;
    cnt_before = wr_cnt;
    #1;
    chk("rst_mid_wr", {fb_wr_en, fb_wr_lru_en}, 2'b00);
    chk("rst_mid_u_ready", bus.u_ready, 1'b1);
    chk("rst_mid_pred_valid", bus.pred_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("rst_no_write", wr_cnt - cnt_before, 0);
    chk("rst_after_ready", {bus.u_ready, bus.f_ready}, 2'b11);
    do_look(32'h5008, '{1'b0, 1'b0, 32'h0});

    chk("pred_queue_drained", pq.size(), 0);
    chk("wr_queue_drained", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
